// File: rtl/xc_pshift_seq.sv
// xc_pshift_seq
// Multi-cycle sequencer for the XCrypto packed shift/rotate instructions
// (xc.psll / xc.psrl / xc.pror). A single narrow lane-masked shifter is
// applied up to STEP bits per BUSY cycle until the lane-masked shift amount
// is consumed. Request and response are valid/ready channels; the rd tag
// travels with the operation and comes back unchanged.

module xc_pshift_seq #(
  parameter int unsigned STEP = 32'd4
) (
  input  logic        g_clk,
  input  logic        g_reset,
  input  logic        flush,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [1:0]  req_pw,
  input  logic [31:0] req_rs1,
  input  logic [4:0]  req_shamt,
  input  logic [4:0]  req_rd,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic [4:0]  rsp_rd,
  output logic        busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_ROR = 2'b10;

  // Per-cycle shift limit, held in the same width as the remaining count.
  localparam logic [4:0] STEP_W = 5'(STEP);

  // Lane-index mask for a pack width: lane width minus one.
  function automatic logic [4:0] lane_mask(input logic [1:0] pw);
    logic [4:0] m;
    case (pw)
      2'd0:    m = 5'd31;
      2'd1:    m = 5'd15;
      2'd2:    m = 5'd7;
      2'd3:    m = 5'd3;
      default: m = 5'd31;
    endcase
    return m;
  endfunction

  // One shifter pass: every lane shifted/rotated by k bits independently.
  // Shift amounts never exceed the lane width, so the 5-bit rotate sum
  // wrapped by the lane mask is always the correct in-lane source bit.
  function automatic logic [31:0] lane_op(input logic [31:0] src,
                                          input logic [1:0]  op,
                                          input logic [1:0]  pw,
                                          input logic [4:0]  k);
    logic [31:0] res;
    logic [4:0]  msk;
    logic [4:0]  bi;
    logic [4:0]  pos;
    logic [4:0]  base;
    logic [5:0]  reach;
    res = 32'd0;
    msk = lane_mask(pw);
    for (int i = 0; i < 32; i++) begin
      bi    = 5'(i);
      pos   = bi & msk;
      base  = bi & ~msk;
      reach = {1'b0, pos} + {1'b0, k};
      case (op)
        OP_SRL: begin
          if (reach <= {1'b0, msk}) begin
            res[bi] = src[bi + k];
          end else begin
            res[bi] = 1'b0;
          end
        end
        OP_ROR: begin
          res[bi] = src[base | ((pos + k) & msk)];
        end
        default: begin
          // SLL, and the reserved encoding which behaves as SLL.
          if (pos >= k) begin
            res[bi] = src[bi - k];
          end else begin
            res[bi] = 1'b0;
          end
        end
      endcase
    end
    return res;
  endfunction

  state_t      state_r;
  state_t      state_nxt_s;
  logic [31:0] acc_r;
  logic [4:0]  rem_r;
  logic [1:0]  op_r;
  logic [1:0]  pw_r;
  logic [4:0]  rd_r;

  logic        accept_s;
  logic [4:0]  req_rem_s;
  logic [4:0]  k_s;
  logic [4:0]  rem_left_s;
  logic [31:0] acc_step_s;

  // Request handshake: open in IDLE, or in DONE when the result leaves this cycle.
  always_comb begin
    req_ready = 1'b0;
    if (flush) begin
      req_ready = 1'b0;
    end else if (state_r == ST_IDLE) begin
      req_ready = 1'b1;
    end else if ((state_r == ST_DONE) && rsp_ready) begin
      req_ready = 1'b1;
    end else begin
      req_ready = 1'b0;
    end
  end

  assign accept_s  = req_valid & req_ready;
  assign req_rem_s = req_shamt & lane_mask(req_pw);

  // Step size and the shifter pass for the current BUSY cycle.
  always_comb begin
    k_s = rem_r;
    if (rem_r > STEP_W) begin
      k_s = STEP_W;
    end else begin
      k_s = rem_r;
    end
    rem_left_s = rem_r - k_s;
    acc_step_s = lane_op(acc_r, op_r, pw_r, k_s);
  end

  // Next-state logic; flush overrides everything, including a pending accept.
  always_comb begin
    state_nxt_s = state_r;
    if (flush) begin
      state_nxt_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            state_nxt_s = (req_rem_s == 5'd0) ? ST_DONE : ST_BUSY;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_BUSY: begin
          if (rem_left_s == 5'd0) begin
            state_nxt_s = ST_DONE;
          end else begin
            state_nxt_s = ST_BUSY;
          end
        end
        ST_DONE: begin
          if (accept_s) begin
            state_nxt_s = (req_rem_s == 5'd0) ? ST_DONE : ST_BUSY;
          end else if (rsp_ready) begin
            state_nxt_s = ST_IDLE;
          end else begin
            state_nxt_s = ST_DONE;
          end
        end
        default: begin
          state_nxt_s = ST_IDLE;
        end
      endcase
    end
  end

  // State register and operand/accumulator datapath.
  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      state_r <= ST_IDLE;
      acc_r   <= 32'd0;
      rem_r   <= 5'd0;
      op_r    <= 2'd0;
      pw_r    <= 2'd0;
      rd_r    <= 5'd0;
    end else begin
      state_r <= state_nxt_s;
      if (accept_s) begin
        acc_r <= req_rs1;
        rem_r <= req_rem_s;
        op_r  <= req_op;
        pw_r  <= req_pw;
        rd_r  <= req_rd;
      end else if ((state_r == ST_BUSY) && !flush) begin
        acc_r <= acc_step_s;
        rem_r <= rem_left_s;
      end else begin
        acc_r <= acc_r;
        rem_r <= rem_r;
      end
    end
  end

  // Outputs are direct decodes of registered state, so they hold steady
  // for as long as the consumer stalls.
  assign rsp_valid  = (state_r == ST_DONE);
  assign busy       = (state_r != ST_IDLE);
  assign rsp_result = acc_r;
  assign rsp_rd     = rd_r;

endmodule
